// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back arbiter.
//   DEF_DATA_W / DEF_ADDR_W / DEF_NREGS : default widths and register count
//   req_id_e                            : requester identity (A = ALU, B = load)
//   other_req()                         : the requester that is not the one given
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NREGS  = 32;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  function automatic req_id_e other_req(input req_id_e r);
    return (r == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two requesters, the arbiter and the register file.
//   a_valid/a_ready/a_addr/a_data : ALU write-back request channel
//   b_valid/b_ready/b_addr/b_data : load-return write-back request channel
//   wr_le/wr_data/wr_en/wr_addr   : write stage driving the Register32 LE/D pins
//
// Handshake: a request transfers on a rising edge where valid && ready are both
// high. Ready may depend combinationally on valid. A requester whose valid is
// high and not yet accepted keeps valid, addr and data stable until accepted.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
);

  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;

  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;

  logic [NREGS-1:0]  wr_le;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  // Requester / observer side.
  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready,
    input  wr_le, wr_data, wr_en, wr_addr
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready,
    output wr_le, wr_data, wr_en, wr_addr
  );

endinterface

// File: rtl/regfile_wb_arbiter_decoder.sv
// Register-address decoder: one-hot load enable per register.
//   addr_i   : register address
//   en_i     : decode enable; when low the output is all zero
//   onehot_o : one bit per register, bit addr_i set when enabled
module reg_addr_decoder #(
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              en_i,
  output logic [NREGS-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (en_i && (addr_i == ADDR_W'(i))) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester round-robin write-back arbiter for the register file.
// Grants one of the ALU (A) or load-return (B) write-backs per cycle, registers
// the winner into a one-cycle write stage that drives the Register32 LE/D pins,
// and offers a forwarding match against a read-port address.
//   Clk        : clock, rising edge
//   Clr        : asynchronous active-low reset
//   hold       : suppresses all grants while high
//   wb         : write-back bus (slave side), see regfile_wb_arbiter_if
//   rd_addr    : read-port address checked against the in-flight write
//   fwd_hit    : in-flight write targets rd_addr (never for register 0)
//   fwd_data   : data of the in-flight write
//   last_grant : requester granted most recently (0 = A, 1 = B)
//   rr_ptr     : round-robin pointer, exposed for observation
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = DEF_NREGS
) (
  input  logic                 Clk,
  input  logic                 Clr,
  input  logic                 hold,
  regfile_wb_arbiter_if.slave  wb,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic                 fwd_hit,
  output logic [DATA_W-1:0]    fwd_data,
  output logic                 last_grant,
  output logic                 rr_ptr
);

  req_id_e           rr_ptr_q,     rr_ptr_d;
  req_id_e           last_grant_q, last_grant_d;
  logic              wr_en_q,      wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,    wr_data_d;

  logic              grant_a;
  logic              grant_b;
  logic              contend;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Grant and next-state logic. Grants are also gated by Clr so that neither
  // ready can rise while the block is held in reset.
  always_comb begin
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    contend      = wb.a_valid && wb.b_valid;
    rr_ptr_d     = rr_ptr_q;
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    if (Clr && !hold) begin
      if (contend) begin
        grant_a = (rr_ptr_q == REQ_A);
        grant_b = (rr_ptr_q == REQ_B);
      end else begin
        grant_a = wb.a_valid;
        grant_b = wb.b_valid;
      end
    end

    xfer     = grant_a || grant_b;
    sel_addr = grant_b ? wb.b_addr : wb.a_addr;
    sel_data = grant_b ? wb.b_data : wb.a_data;

    if (xfer) begin
      last_grant_d = grant_b ? REQ_B : REQ_A;
      // Register 0 is hardwired zero: accept the write but never present it.
      wr_en_d      = (sel_addr != '0);
      wr_addr_d    = sel_addr;
      wr_data_d    = sel_data;
      // The pointer only moves on contention, and then to the loser.
      if (contend) begin
        rr_ptr_d = other_req(last_grant_d);
      end
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      rr_ptr_q     <= REQ_A;
      last_grant_q <= REQ_A;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  reg_addr_decoder #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_dec (
    .addr_i   (wr_addr_q),
    .en_i     (wr_en_q),
    .onehot_o (wb.wr_le)
  );

  assign wb.a_ready = grant_a;
  assign wb.b_ready = grant_b;
  assign wb.wr_en   = wr_en_q;
  assign wb.wr_addr = wr_addr_q;
  assign wb.wr_data = wr_data_q;

  assign fwd_hit    = wr_en_q && (wr_addr_q == rd_addr) && (rd_addr != '0);
  assign fwd_data   = wr_data_q;
  assign last_grant = last_grant_q;
  assign rr_ptr     = rr_ptr_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          Clk;
  logic          Clr;
  logic          hold;
  logic [AW-1:0] rd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          last_grant;
  logic          rr_ptr;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR)) wb ();

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR)) dut (
    .Clk        (Clk),
    .Clr        (Clr),
    .hold       (hold),
    .wb         (wb),
    .rd_addr    (rd_addr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .last_grant (last_grant),
    .rr_ptr     (rr_ptr)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Stand-in for the Register32 bank fed by LE/D (not reset by this block).
  logic [DW-1:0] rf_q [NR];
  initial for (int i = 0; i < NR; i++) rf_q[i] = '0;
  always @(posedge Clk) begin
    for (int i = 0; i < NR; i++) if (wb.wr_le[i]) rf_q[i] <= wb.wr_data;
  end

  // ---------------- reference model ----------------
  // Pending write presented in the following cycle, arbitration history,
  // and the architectural register contents.
  int            checks = 0;
  int            errors = 0;
  int            m_rr;      // requester favoured on the next contention
  int            m_last;
  bit            m_en;
  bit            m_known;   // wr_addr/wr_data have a defined expectation
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_rf [NR];

  bit            ga, gb, av, bv, hl;
  logic [AW-1:0] aa, ba, rd;
  logic [DW-1:0] ad, bd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_last = 0; m_en = 1'b0; m_known = 1'b1;
    m_addr = '0; m_data = '0;
  endtask

  task automatic post_checks();
    int mism;
    logic [NR-1:0] exp_le;
    exp_le = m_en ? (NR'(1) << m_addr) : '0;
    chk("wr_en",      64'(wb.wr_en),    64'(m_en));
    chk("wr_le",      64'(wb.wr_le),    64'(exp_le));
    chk("last_grant", 64'(last_grant),  64'(m_last));
    chk("rr_ptr",     64'(rr_ptr),      64'(m_rr));
    if (m_known) begin
      chk("wr_addr", 64'(wb.wr_addr), 64'(m_addr));
      chk("wr_data", 64'(wb.wr_data), 64'(m_data));
    end
    mism = 0;
    for (int i = 0; i < NR; i++) if (rf_q[i] !== m_rf[i]) mism++;
    chk("regfile", 64'(mism), 64'd0);
  endtask

  // One cycle: drive requests at the negedge, check readies/forwarding,
  // advance the model across the rising edge, check the write stage.
  task automatic step(input bit a_v, input logic [AW-1:0] a_a, input logic [DW-1:0] a_d,
                      input bit b_v, input logic [AW-1:0] b_a, input logic [DW-1:0] b_d,
                      input bit h, input logic [AW-1:0] r,
                      output bit g_a, output bit g_b);
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_data;
    wb.a_valid = a_v; wb.a_addr = a_a; wb.a_data = a_d;
    wb.b_valid = b_v; wb.b_addr = b_a; wb.b_data = b_d;
    hold = h; rd_addr = r;
    #1;
    g_a = 1'b0; g_b = 1'b0;
    if (!h) begin
      if (a_v && b_v) begin
        g_a = (m_rr == 0);
        g_b = (m_rr == 1);
      end else begin
        g_a = a_v;
        g_b = b_v;
      end
    end
    chk("a_ready", 64'(wb.a_ready), 64'(g_a));
    chk("b_ready", 64'(wb.b_ready), 64'(g_b));
    chk("fwd_hit", 64'(fwd_hit), 64'(m_en && (m_addr == r) && (r != 0)));
    if (m_en) chk("fwd_data", 64'(fwd_data), 64'(m_data));
    @(posedge Clk);
    if (m_en) m_rf[m_addr] = m_data;
    m_en = 1'b0;
    if (g_a || g_b) begin
      t_addr  = g_b ? b_a : a_a;
      t_data  = g_b ? b_d : a_d;
      m_last  = g_b ? 1 : 0;
      if (a_v && b_v) m_rr = g_a ? 1 : 0;
      m_en    = (t_addr != 0);
      m_known = (t_addr != 0);
      m_addr  = t_addr;
      m_data  = t_data;
    end
    @(negedge Clk);
    post_checks();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int i = 0; i < NR; i++) m_rf[i] = '0;
    model_reset();

    // Reset: outputs cleared, readies low even with requests pending.
    Clr = 1'b0; hold = 1'b0; rd_addr = '0;
    wb.a_valid = 1'b1; wb.a_addr = 5'd4; wb.a_data = 32'h1111_1111;
    wb.b_valid = 1'b1; wb.b_addr = 5'd6; wb.b_data = 32'h2222_2222;
    #12;
    chk("rst_a_ready", 64'(wb.a_ready),   64'd0);
    chk("rst_b_ready", 64'(wb.b_ready),   64'd0);
    chk("rst_wr_en",   64'(wb.wr_en),     64'd0);
    chk("rst_wr_le",   64'(wb.wr_le),     64'd0);
    chk("rst_wr_addr", 64'(wb.wr_addr),   64'd0);
    chk("rst_wr_data", 64'(wb.wr_data),   64'd0);
    chk("rst_last",    64'(last_grant),   64'd0);
    chk("rst_rr",      64'(rr_ptr),       64'd0);
    @(negedge Clk);
    wb.a_valid = 1'b0; wb.b_valid = 1'b0;
    Clr = 1'b1;

    // Single A write to register 3, then an idle cycle to see it land.
    step(1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 5'd0, ga, gb);
    chk("r3_wr_le", 64'(wb.wr_le), 64'h8);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, ga, gb);
    chk("r3_q", 64'(rf_q[3]), 64'hDEADBEEF);

    // Contention for four cycles: alternating A,B,A,B.
    for (int k = 0; k < 4; k++) begin
      step(1, 5'd1, 32'hA000_0000 + 32'(k), 1, 5'd2, 32'hB000_0000 + 32'(k), 0, 5'd0, ga, gb);
      chk("rr_seq_grant_b", 64'(gb), 64'(k % 2));
      chk("rr_seq_wr_le", 64'(wb.wr_le), (k % 2 == 0) ? 64'h2 : 64'h4);
    end

    // B write to register 0: accepted, last_grant moves, nothing presented.
    step(0, 5'd0, 32'h0, 1, 5'd0, 32'hCAFEBABE, 0, 5'd0, ga, gb);
    chk("r0_wr_en", 64'(wb.wr_en), 64'd0);

    // Forwarding against an in-flight write to register 7.
    step(1, 5'd7, 32'h12345678, 0, 5'd0, 32'h0, 0, 5'd0, ga, gb);
    wb.a_valid = 1'b0;
    rd_addr = 5'd6; #1;
    chk("fwd_miss6", 64'(fwd_hit), 64'd0);
    rd_addr = 5'd0; #1;
    chk("fwd_miss0", 64'(fwd_hit), 64'd0);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd7, ga, gb);

    // Hold with both valid, then release.
    step(1, 5'd9, 32'h9999_0009, 1, 5'd10, 32'hAAAA_000A, 1, 5'd0, ga, gb);
    step(1, 5'd9, 32'h9999_0009, 1, 5'd10, 32'hAAAA_000A, 1, 5'd0, ga, gb);
    step(1, 5'd9, 32'h9999_0009, 1, 5'd10, 32'hAAAA_000A, 0, 5'd0, ga, gb);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, ga, gb);

    // Contention with A winning toward register 5 leaves rr on B; a reset
    // pulse during the write stage must drop the write and restore rr to A.
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, ga, gb);
    if (m_rr != 0) step(1, 5'd11, 32'h0B0B_0B0B, 1, 5'd12, 32'h0C0C_0C0C, 0, 5'd0, ga, gb);
    step(1, 5'd5, 32'h5555_AAAA, 1, 5'd9, 32'h0909_0909, 0, 5'd0, ga, gb);
    chk("pre_clr_wr_en", 64'(wb.wr_en), 64'd1);
    Clr = 1'b0; #1;
    chk("clr_wr_le",   64'(wb.wr_le),   64'd0);
    chk("clr_wr_en",   64'(wb.wr_en),   64'd0);
    chk("clr_a_ready", 64'(wb.a_ready), 64'd0);
    chk("clr_rr",      64'(rr_ptr),     64'd0);
    wb.a_valid = 1'b0; wb.b_valid = 1'b0;
    #1 Clr = 1'b1;
    model_reset();
    @(negedge Clk);
    chk("clr_r5_kept", 64'(rf_q[5]), 64'(m_rf[5]));
    post_checks();
    // First contention after reset goes to A.
    step(1, 5'd1, 32'h0101_0101, 1, 5'd2, 32'h0202_0202, 0, 5'd0, ga, gb);
    chk("post_clr_grant_a", 64'(ga), 64'd1);

    // Randomized traffic; unaccepted requests stay stable.
    av = 0; bv = 0; aa = '0; ba = '0; ad = '0; bd = '0; ga = 0; gb = 0;
    for (int n = 0; n < 400; n++) begin
      if (!(av && !ga)) begin
        av = ($urandom_range(0, 2) != 0);
        aa = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(0, NR - 1));
        ad = $urandom;
      end
      if (!(bv && !gb)) begin
        bv = ($urandom_range(0, 2) != 0);
        ba = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(0, NR - 1));
        bd = $urandom;
      end
      hl = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 1) == 1) ? m_addr : AW'($urandom_range(0, NR - 1));
      step(av, aa, ad, bv, ba, bd, hl, rd, ga, gb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: write-data width.
REQ-002 SHALL have parameter ADDR_W, default 5: register address width.
REQ-003 SHALL have parameter NREGS, default 32: number of Register32 instances driven.
REQ-004 Clk  in  1  single clock; all state changes on the rising edge.
REQ-005 Clr  in  1  asynchronous, active-low reset.
REQ-006 hold  in  1  when high, no grants are issued.
REQ-007 a_valid / a_ready  in / out  1 / 1  ALU write-back request and its acceptance.
REQ-008 a_addr / a_data  in / in  ADDR_W / DATA_W  ALU target register and result.
REQ-009 b_valid / b_ready  in / out  1 / 1  load-return write-back request and its acceptance.
REQ-010 b_addr / b_data  in / in  ADDR_W / DATA_W  load target register and data.
REQ-011 wr_le  out  NREGS  one-hot load enables, one per Register32 LE input.
REQ-012 wr_data  out  DATA_W  common D bus to all registers.
REQ-013 wr_en / wr_addr  out / out  1 / ADDR_W  write-stage valid and address.
REQ-014 rd_addr  in  ADDR_W  read-port address for forwarding check.
REQ-015 fwd_hit / fwd_data  out / out  1 / DATA_W  in-flight write matches rd_addr, plus its data.
REQ-016 last_grant  out  1  0 = A, 1 = B; requester granted most recently.

Function
REQ-017 Grant (combinational) SHALL be: none if hold=1; A if only a_valid; B if only b_valid; rr_ptr's choice if both valid.
REQ-018 a_ready / b_ready SHALL equal the corresponding grant; at most one SHALL be high in any cycle.
REQ-019 A transfer SHALL occur when valid && ready on a rising edge; a non-granted request SHALL be held by its requester with addr and data stable.
REQ-020 rr_ptr SHALL toggle only after a grant made with both requesters valid, pointing to the non-granted requester.
REQ-021 A transfer in cycle N SHALL register wr_en=1, wr_addr and wr_data for cycle N+1, and the addressed register SHALL capture the data on the edge ending N+1. Latency is 1 cycle; throughput is one write per cycle.
REQ-022 wr_le SHALL be the one-hot decode of wr_addr gated by wr_en; otherwise all zero.
REQ-023 Address 0 (GR0 hardwired zero): the transfer SHALL be accepted and rr_ptr and last_grant updated, but wr_en SHALL be 0 and wr_le SHALL be all zero in the next cycle.
REQ-024 fwd_hit SHALL equal wr_en && (wr_addr == rd_addr) && (rd_addr != 0), combinationally; fwd_data SHALL equal wr_data.
REQ-025 With no transfer in cycle N, wr_en SHALL be 0 in N+1; wr_data and wr_addr SHALL hold their previous values.
REQ-026 last_grant SHALL update on every transfer, including address-0 transfers.

Reset
REQ-027 Clr=0 SHALL asynchronously force wr_en=0, wr_le=0, wr_addr=0, wr_data=0, rr_ptr=A, last_grant=0.
REQ-028 A write in flight when Clr asserts SHALL be discarded and never presented on wr_le.
REQ-029 a_ready / b_ready SHALL be 0 while Clr=0.
REQ-030 The first grant after Clr deassertion SHALL obey REQ-017 with rr_ptr=A.

Structure
REQ-031 Package regfile_pkg SHALL hold DATA_W, ADDR_W, NREGS defaults and the requester-id enum (REQ_A=0, REQ_B=1).
REQ-032 Address decode SHALL be a sub-module reg_addr_decoder (ADDR_W in, NREGS one-hot out, enable input).
REQ-033 The block SHALL drive the existing Register32 LE/D pins directly; register Clr wiring is outside this block.

Verification
REQ-034 Only A valid, a_addr=3, a_data=DEADBEEF -> a_ready=1; next cycle wr_le=0x00000008, wr_data=DEADBEEF; register 3 Q=DEADBEEF one edge later.
REQ-035 A and B valid for 4 cycles after reset (A addr 1, B addr 2) -> grants A,B,A,B; wr_le sequence 0x2,0x4,0x2,0x4.
REQ-036 B valid, b_addr=0, b_data=CAFEBABE -> b_ready=1, last_grant=1, next cycle wr_en=0 and wr_le=0.
REQ-037 A writes addr 7 = 12345678; in the write cycle rd_addr=7 -> fwd_hit=1, fwd_data=12345678; rd_addr=0 or 6 -> fwd_hit=0.
REQ-038 hold=1 with both valid -> both ready=0 and wr_en=0 next cycle; on hold release, grant follows unchanged rr_ptr.
REQ-039 Clr pulsed low mid-cycle during an in-flight write to addr 5 -> wr_le=0 immediately, register 5 unchanged, rr_ptr=A afterwards.
